// File: rtl/data_ram_wb_slave_pkg.sv
// Shared types and constants for the Wishbone data RAM slave.
// FSM encoding, wait-counter width and big-endian byte-lane masks.
package data_ram_wb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // sel[3] is the lowest byte address (bits 31:24)
  localparam logic [3:0] SEL_B0    = 4'b1000;
  localparam logic [3:0] SEL_B1    = 4'b0100;
  localparam logic [3:0] SEL_B2    = 4'b0010;
  localparam logic [3:0] SEL_B3    = 4'b0001;
  localparam logic [3:0] SEL_HALF0 = 4'b1100;
  localparam logic [3:0] SEL_HALF1 = 4'b0011;
  localparam logic [3:0] SEL_WORD  = 4'b1111;

  function automatic logic [3:0] lane_we(
    input logic       en,
    input logic [3:0] sel
  );
    return {4{en}} & sel;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word-organised data RAM with per-byte-lane write enables
// and a registered synchronous read port.
module data_ram_array #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read register holds until the next completed read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_wb_slave.sv
// Wishbone classic data RAM slave with programmable wait states.
// Define DATA_RAM_ERR_EN to flag out-of-range addresses with wb_err_o.
module data_ram_wb_slave
  import data_ram_wb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam logic [CNT_W-1:0] WAIT_LD = WAIT_CYCLES[CNT_W-1:0];
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_we;
  logic [3:0]            r_sel;
  logic [31:0]           r_dat;
  logic                  r_oor;

  logic                  req;
  logic [ADDR_WIDTH-1:0] bus_idx;
  logic                  bus_oor;
  logic                  unused_adr;

  logic                  go_now;
  logic                  go_wait;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic                  c_we;
  logic [3:0]            c_sel;
  logic [31:0]           c_dat;
  logic                  c_oor;

  logic [3:0]            ram_we;
  logic                  ram_re;

  assign req     = wb_cyc_i & wb_stb_i;
  assign bus_idx = wb_adr_i[ADDR_WIDTH+1:2];

`ifdef DATA_RAM_ERR_EN
  localparam logic [31:0] HI_MASK = 32'hFFFF_FFFF << (ADDR_WIDTH + 2);
  assign bus_oor    = |(wb_adr_i & HI_MASK);
  assign unused_adr = ^wb_adr_i[1:0];
`else
  assign bus_oor    = 1'b0;
  assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif

  // Zero-wait transfers commit straight from the bus, others from latches
  assign go_now  = (state == ST_IDLE) & req & ZERO_WAIT;
  assign go_wait = (state == ST_WAIT) & wb_cyc_i & (cnt == 4'd1);
  assign commit  = go_now | go_wait;

  assign c_idx = go_now ? bus_idx  : r_idx;
  assign c_we  = go_now ? wb_we_i  : r_we;
  assign c_sel = go_now ? wb_sel_i : r_sel;
  assign c_dat = go_now ? wb_dat_i : r_dat;
  assign c_oor = go_now ? bus_oor  : r_oor;

  assign ram_we = lane_we(commit & c_we & ~c_oor, c_sel);
  assign ram_re = commit & ~c_we & ~c_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      r_idx <= '0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_dat <= '0;
      r_oor <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            r_idx <= bus_idx;
            r_we  <= wb_we_i;
            r_sel <= wb_sel_i;
            r_dat <= wb_dat_i;
            r_oor <= bus_oor;
            if (ZERO_WAIT) begin
              state <= ST_RESP;
            end else begin
              cnt   <= WAIT_LD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= ST_RESP;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
    end else begin
      wb_ack_o <= commit & ~c_oor;
    end
  end

`ifdef DATA_RAM_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_err_o <= 1'b0;
    end else begin
      wb_err_o <= commit & c_oor;
    end
  end
`else
  assign wb_err_o = 1'b0;
`endif

  data_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .re   (ram_re),
    .addr (c_idx),
    .wdata(c_dat),
    .rdata(wb_dat_o)
  );

endmodule

// File: tb/tb_data_ram_wb_slave.sv
// Bench for data_ram_wb_slave: one instance with one wait state,
// one with zero wait states; vector table, corner sequences, random model.
module tb_data_ram_wb_slave;
  import data_ram_wb_slave_pkg::*;

`ifdef DATA_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cyc = '0;
  logic [1:0]  stb = '0;
  logic [1:0]  we  = '0;
  logic [31:0] adr [2];
  logic [3:0]  sel [2];
  logic [31:0] dat [2];
  logic [31:0] dato [2];
  logic [1:0]  ack;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd [2];
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  data_ram_wb_slave #(.ADDR_WIDTH(17), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dat[0]),
    .wb_dat_o(dato[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
  );

  data_ram_wb_slave #(.ADDR_WIDTH(17), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dat[1]),
    .wb_dat_o(dato[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack[i] && err[i]) begin
        errors++;
        $display("FAIL ack_err_excl dut%0d: both high, required at most one", i);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] wd,
                      output int lat, output logic e, output logic [31:0] rd);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; sel[d] = s; dat[d] = wd;
    @(posedge clk);
    lat = -1; e = 1'b0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack[d] || err[d]) begin
        lat = k; e = err[d]; rd = dato[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  task automatic do_op(input int d, input string nm, input logic w,
                       input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rd);
    int lat;
    logic e;
    logic [31:0] rd;
    xfer(d, w, a, s, wd, lat, e, rd);
    chk({nm, "_lat"}, 32'(lat), (d == 1) ? 32'd2 : 32'd1);
    chk({nm, "_err"}, {31'd0, e}, {31'd0, e_err});
    if (!w) begin
      chk({nm, "_rd"}, rd, e_err ? last_rd[d] : e_rd);
      if (!e_err) last_rd[d] = e_rd;
    end
  endtask

  typedef struct {
    string       nm;
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [6];

  initial begin
    int seen;
    int lat;
    logic e;
    logic [31:0] rd;
    logic [5:0] pat;
    logic [16:0] pool [8];

    for (int i = 0; i < 2; i++) begin
      adr[i] = '0; sel[i] = '0; dat[i] = '0; last_rd[i] = '0;
    end

    tv[0] = '{"wr_word",  1'b1, 32'h10, SEL_WORD,  32'h11223344, 32'h0};
    tv[1] = '{"rd_word",  1'b0, 32'h10, SEL_WORD,  32'h0,        32'h11223344};
    tv[2] = '{"wr_byte",  1'b1, 32'h10, SEL_B1,    32'hAABBCCDD, 32'h0};
    tv[3] = '{"rd_byte",  1'b0, 32'h10, SEL_B3,    32'h0,        32'h11BB3344};
    tv[4] = '{"wr_half",  1'b1, 32'h10, SEL_HALF1, 32'h00005566, 32'h0};
    tv[5] = '{"rd_half",  1'b0, 32'h10, 4'b0000,   32'h0,        32'h11BB5566};

    // Reset held with a live strobe
    cyc = 2'b11; stb = 2'b11; we = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_ack%0d", i), {31'd0, ack[i]}, 32'd0);
        chk($sformatf("rst_err%0d", i), {31'd0, err[i]}, 32'd0);
        chk($sformatf("rst_dat%0d", i), dato[i], 32'h0);
      end
    end
    cyc = '0; stb = '0; we = '0;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(1, tv[i].nm, tv[i].w, tv[i].a, tv[i].s, tv[i].d, 1'b0, tv[i].exp);
    end

    // Abort: drop cyc while waiting
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h10; sel[1] = SEL_WORD; dat[1] = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack[1] || err[1]) seen++;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    chk("abort_dat_hold", dato[1], 32'h11BB5566);
    do_op(1, "abort_rd", 1'b0, 32'h10, SEL_WORD, 32'h0, 1'b0, 32'h11BB5566);

    // Reset before the commit edge loses the write
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h10; sel[1] = SEL_WORD; dat[1] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ack[1]) seen++;
    end
    chk("rst_wait_no_ack", 32'(seen), 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    do_op(1, "rst_wait_rd", 1'b0, 32'h10, SEL_WORD, 32'h0, 1'b0, 32'h11BB5566);

    // Range / aliasing at 0x00080000
    do_op(1, "w0_init", 1'b1, 32'h0, SEL_WORD, 32'hCAFEF00D, 1'b0, 32'h0);
    do_op(1, "oor_wr", 1'b1, 32'h00080000, SEL_WORD, 32'h12345678, ERR_EN, 32'h0);
    do_op(1, "oor_w0_rd", 1'b0, 32'h0, SEL_WORD, 32'h0, 1'b0,
          ERR_EN ? 32'hCAFEF00D : 32'h12345678);
    do_op(1, "oor_rd", 1'b0, 32'h00080000, SEL_WORD, 32'h0, ERR_EN, 32'h12345678);

    // Empty byte mask still acknowledges and leaves memory alone
    do_op(1, "sel0_wr", 1'b1, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0, 32'h0);
    do_op(1, "sel0_rd", 1'b0, 32'h0, SEL_WORD, 32'h0, 1'b0,
          ERR_EN ? 32'hCAFEF00D : 32'h12345678);

    // Reset during the response cycle clears ack at once
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0;
    adr[1] = 32'h10; sel[1] = SEL_WORD;
    @(posedge clk);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (ack[1]) seen = 1;
    end
    chk("resp_ack_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    #1;
    chk("resp_rst_ack", {31'd0, ack[1]}, 32'd0);
    chk("resp_rst_dat", dato[1], 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;

    // Back-to-back with no wait states
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h20; sel[0] = SEL_WORD; dat[0] = 32'hA5A5A5A5;
    @(posedge clk);
    pat = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat[c] = ack[0];
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    chk("b2b_ack_pattern", {26'd0, pat}, 32'b010101);
    do_op(0, "b2b_rd", 1'b0, 32'h20, SEL_WORD, 32'h0, 1'b0, 32'hA5A5A5A5);

    // Random traffic against a word-array reference model
    for (int k = 0; k < 8; k++) begin
      pool[k] = 17'($urandom);
      rd = $urandom;
      do_op(1, "rnd_init", 1'b1, {13'd0, pool[k], 2'b00}, SEL_WORD, rd, 1'b0, 32'h0);
      ref_mem[int'(pool[k])] = rd;
    end
    for (int n = 0; n < 150; n++) begin
      logic [16:0] idx;
      logic [12:0] hi;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] m;
      logic [3:0]  s;
      logic        w;
      idx = pool[$urandom_range(0, 7)];
      hi  = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(1, 8191)) : 13'd0;
      a   = {hi, idx, 2'($urandom_range(0, 3))};
      e   = ERR_EN && (hi != 0);
      w   = 1'($urandom_range(0, 1));
      s   = 4'($urandom_range(0, 15));
      wd  = $urandom;
      if (w) begin
        do_op(1, "rnd_wr", 1'b1, a, s, wd, e, 32'h0);
        if (!e) begin
          m = ref_mem[int'(idx)];
          for (int b = 0; b < 4; b++) begin
            if (s[b]) m[b*8 +: 8] = wd[b*8 +: 8];
          end
          ref_mem[int'(idx)] = m;
        end
      end else begin
        do_op(1, "rnd_rd", 1'b0, a, s, 32'h0, e, ref_mem[int'(idx)]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_wb_slave.md
# data_ram_wb_slave

Wishbone classic slave that answers the data-side bus of the OpenMIPS core. Loads and stores leave the memory-access stage with a big-endian byte-select (`sel[3]` = bits 31:24 = byte offset 0), and this block is the memory that responds to them. It holds a word-organised data RAM and performs byte-lane-masked writes and full-word reads. Each transfer is acknowledged after a programmable number of wait states, so bus stall handling can be exercised.

## Interface
Parameters:
- `ADDR_WIDTH`, default 17: word-index bits. RAM holds 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, default 1: wait states inserted before ack. Legal range 0..15.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  transfer strobe.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  32  byte address. Bits [1:0] are ignored.
- `wb_sel_i`  in  4  byte lanes, big-endian (`sel[3]` = `dat[31:24]`).
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, registered.
- `wb_ack_o`  out  1  transfer-complete pulse.
- `wb_err_o`  out  1  error pulse. See Configuration.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On `wb_cyc_i & wb_stb_i`, latch `adr`, `we`, `sel`, `dat`.
  - If `WAIT_CYCLES == 0`, go to RESP.
  - Otherwise load the 4-bit counter with `WAIT_CYCLES` and go to WAIT.
- WAIT:
  - If `wb_cyc_i` drops, abort: go to IDLE with no write, no ack and `wb_dat_o` unchanged.
  - Otherwise decrement the counter. On the edge where the counter equals 1, go to RESP.
- Commit edge: the edge entering RESP.
  - A write updates only the lanes whose `sel` bit is set.
  - A read loads the full stored word into `wb_dat_o`, whatever `sel` is; the master extracts bytes.
  - `sel == 0000` on a write: ack is returned and memory is unchanged.
- RESP:
  - `wb_ack_o` (or `wb_err_o`) is high for exactly this one cycle.
  - Next state is always IDLE.
  - A strobe held during RESP is not sampled; it is taken again in IDLE.
- Word index is `adr[ADDR_WIDTH+1:2]`.
- `wb_dat_o` holds its value until the next completed read.
- RAM contents are not reset.

## Timing
- Request sampled at edge N → ack high in cycle N+1+WAIT_CYCLES.
- Read data is valid in the same cycle as ack.
- Throughput: one transfer per WAIT_CYCLES+2 cycles.
- Reset values: state IDLE, counter 0, `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0.
- `rst` asserted before the commit edge: the write is lost and no ack is produced.
- `rst` asserted in RESP: ack is cleared immediately (async).
- `wb_ack_o` and `wb_err_o` are never high together.

## Configuration
- `DATA_RAM_ERR_EN` defined:
  - Any set bit in `adr[31:ADDR_WIDTH+2]` is out of range.
  - The transfer runs the same FSM and wait states, then pulses `wb_err_o` instead of `wb_ack_o`.
  - No write is performed and `wb_dat_o` is unchanged.
- `DATA_RAM_ERR_EN` undefined:
  - Upper address bits are ignored, so addresses alias modulo RAM size.
  - `wb_err_o` is tied to 0.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/WAIT/RESP).
  - 4-bit wait-counter width.
  - Big-endian lane constants (`SEL_B0`=1000 … `SEL_B3`=0001, `SEL_HALF0`=1100, `SEL_HALF1`=0011, `SEL_WORD`=1111).
- Sub-module `data_ram_array`:
  - 2^ADDR_WIDTH × 32 storage.
  - Four per-byte-lane write enables.
  - Synchronous read into an output register.
- Top level contains the FSM, the counter, request latches and range check.

## Test plan
- Reset: hold `rst`=1 with `stb`=1 → `ack`=0, `err`=0, `wb_dat_o`=0x00000000 throughout.
- Word round trip (WAIT_CYCLES=1):
  - Write 0x11223344 to 0x10 with sel 1111 → ack exactly 2 cycles after the sample edge.
  - Read 0x10 → 0x11223344 with ack.
- Byte lane: over 0x11223344, write 0xAABBCCDD with sel 0100 → read returns 0x11BB3344.
- Half-word lane: write 0x5566 with sel 0011 → read returns 0x11BB5566.
- Abort: drop `cyc` in WAIT during a write of 0xFFFFFFFF to 0x10 → no ack; read still returns the old word.
- Range (ADDR_WIDTH=17), address 0x00080000:
  - With `DATA_RAM_ERR_EN`: single `err` pulse, no ack, word 0 unchanged.
  - Without it: write lands at word 0.
- Back-to-back (WAIT_CYCLES=0), `stb` held high for 6 cycles → ack in cycles 1, 3, 5 and three transfers completed.
